// File: rtl/spike_scheduler_pkg.sv
// Shared configuration for the spike scheduler: event kinds, opcodes, word
// geometry and the default-width instruction packers.
package spike_scheduler_pkg;

  localparam int NET_NUM_INP      = 4;
  localparam int NET_CHARGE_WIDTH = 8;
  localparam int OPC_WIDTH        = 2;
  localparam int RUN_WIDTH_DEF    = 8;

  localparam int IDX_WIDTH = (NET_NUM_INP > 1) ? $clog2(NET_NUM_INP) : 1;
  // A single-input network carries no index bits in the SPK payload.
  localparam int IDX_BITS  = (NET_NUM_INP > 1) ? IDX_WIDTH : 0;
  localparam int SPK_WIDTH = IDX_BITS + NET_CHARGE_WIDTH;

  function automatic int ins_width(input int run_w);
    return OPC_WIDTH + ((run_w > SPK_WIDTH) ? run_w : SPK_WIDTH);
  endfunction

  localparam int INS_WIDTH = ins_width(RUN_WIDTH_DEF);

  typedef enum logic [1:0] {
    EVT_SPK = 2'd0,
    EVT_ADV = 2'd1,
    EVT_CLR = 2'd2
  } evt_kind_t;

  typedef enum logic [OPC_WIDTH-1:0] {
    OPC_NOP = 2'd0,
    OPC_RUN = 2'd1,
    OPC_SPK = 2'd2,
    OPC_CLR = 2'd3
  } opc_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN_EMIT = 2'd1,
    ST_OP_EMIT  = 2'd2
  } state_t;

  function automatic opc_t kind_to_opc(input evt_kind_t k);
    return (k == EVT_CLR) ? OPC_CLR : OPC_SPK;
  endfunction

  function automatic logic [INS_WIDTH-1:0] pack_run(input logic [RUN_WIDTH_DEF-1:0] cnt);
    logic [INS_WIDTH-1:0] w;
    w = '0;
    w[INS_WIDTH-1 -: OPC_WIDTH] = OPC_RUN;
    w[INS_WIDTH-OPC_WIDTH-1 -: RUN_WIDTH_DEF] = cnt;
    return w;
  endfunction

  function automatic logic [INS_WIDTH-1:0] pack_spk(input logic [SPK_WIDTH-1:0] payload);
    logic [INS_WIDTH-1:0] w;
    w = '0;
    w[INS_WIDTH-1 -: OPC_WIDTH] = OPC_SPK;
    w[INS_WIDTH-OPC_WIDTH-1 -: SPK_WIDTH] = payload;
    return w;
  endfunction

  function automatic logic [INS_WIDTH-1:0] pack_clr();
    logic [INS_WIDTH-1:0] w;
    w = '0;
    w[INS_WIDTH-1 -: OPC_WIDTH] = OPC_CLR;
    return w;
  endfunction

endpackage

// File: rtl/spike_scheduler_ins_pack.sv
// Combinational encoder: {op, run count, idx, val} -> instruction word with
// the opcode in the MSBs, payload directly below and zero padding at the LSBs.
module spike_scheduler_ins_pack
  import spike_scheduler_pkg::*;
#(
  parameter int RUN_WIDTH = 8,
  localparam int INS_W = ins_width(RUN_WIDTH)
) (
  input  opc_t                               op,
  input  logic [RUN_WIDTH-1:0]               count,
  input  logic [IDX_WIDTH-1:0]               idx,
  input  logic signed [NET_CHARGE_WIDTH-1:0] val,
  output logic [INS_W-1:0]                   ins
);

  logic [SPK_WIDTH-1:0] spk_field;

  if (IDX_BITS > 0) begin : g_idx
    assign spk_field = {idx, val};
  end else begin : g_noidx
    assign spk_field = val;
  end

  always_comb begin
    ins = '0;
    ins[INS_W-1 -: OPC_WIDTH] = op;
    case (op)
      OPC_RUN: ins[INS_W-OPC_WIDTH-1 -: RUN_WIDTH] = count;
      OPC_SPK: ins[INS_W-OPC_WIDTH-1 -: SPK_WIDTH] = spk_field;
      default: ;
    endcase
  end

endmodule

// File: rtl/spike_scheduler.sv
// Expands time-stamped events into RUN chunks (split at RUN_MAX) followed by
// the event's SPK/CLR word, and tracks the issued network time.
module spike_scheduler
  import spike_scheduler_pkg::*;
#(
  parameter int RUN_WIDTH  = 8,
  parameter int DT_WIDTH   = 16,
  parameter int TIME_WIDTH = 32,
  localparam int INS_W = ins_width(RUN_WIDTH)
) (
  input  logic                               clk,
  input  logic                               arstn,
  input  logic                               evt_valid,
  output logic                               evt_ready,
  input  evt_kind_t                          evt_kind,
  input  logic [DT_WIDTH-1:0]                evt_dt,
  input  logic [IDX_WIDTH-1:0]               evt_idx,
  input  logic signed [NET_CHARGE_WIDTH-1:0] evt_val,
  output logic                               ins_valid,
  input  logic                               ins_ready,
  output logic [INS_W-1:0]                   ins,
  output logic                               busy,
  output logic [TIME_WIDTH-1:0]              time_now
);

  localparam int XW = (DT_WIDTH > RUN_WIDTH) ? DT_WIDTH : RUN_WIDTH;

  state_t                              state_q, state_d;
  logic [DT_WIDTH-1:0]                 remain_q, remain_d;
  evt_kind_t                           kind_q, kind_d;
  logic [IDX_WIDTH-1:0]                idx_q, idx_d;
  logic signed [NET_CHARGE_WIDTH-1:0]  val_q, val_d;
  logic [INS_W-1:0]                    ins_q, ins_d;
  logic                                ins_valid_q, ins_valid_d;
  logic [TIME_WIDTH-1:0]               time_q, time_d;

  logic                 slot_free, ins_hs, evt_acc;
  logic [DT_WIDTH-1:0]  src, remain_after;
  logic [XW-1:0]        src_x, run_max_x, chunk_x;
  logic [RUN_WIDTH-1:0] chunk;
  opc_t                 pk_op, ins_opc;
  logic [IDX_WIDTH-1:0] pk_idx;
  logic signed [NET_CHARGE_WIDTH-1:0] pk_val;
  logic [INS_W-1:0]     pk_word;
  logic [RUN_WIDTH-1:0] ins_cnt;

  assign slot_free = !ins_valid_q || ins_ready;
  assign ins_hs    = ins_valid_q && ins_ready;
  assign evt_ready = (state_q == ST_IDLE) && slot_free;
  assign evt_acc   = evt_valid && evt_ready;

  // Chunking works in a width covering both dt and the RUN count, so the
  // chunk never exceeds what is left and remain cannot underflow.
  always_comb begin
    src       = (state_q == ST_IDLE) ? evt_dt : remain_q;
    src_x     = '0;
    src_x[DT_WIDTH-1:0] = src;
    run_max_x = '0;
    run_max_x[RUN_WIDTH-1:0] = '1;
    chunk_x   = (src_x > run_max_x) ? run_max_x : src_x;
    chunk     = chunk_x[RUN_WIDTH-1:0];
    remain_after = src - chunk_x[DT_WIDTH-1:0];
  end

  assign pk_idx = (state_q == ST_IDLE) ? evt_idx : idx_q;
  assign pk_val = (state_q == ST_IDLE) ? evt_val : val_q;

  spike_scheduler_ins_pack #(
    .RUN_WIDTH(RUN_WIDTH)
  ) u_pack (
    .op   (pk_op),
    .count(chunk),
    .idx  (pk_idx),
    .val  (pk_val),
    .ins  (pk_word)
  );

  assign ins_opc = opc_t'(ins_q[INS_W-1 -: OPC_WIDTH]);
  assign ins_cnt = ins_q[INS_W-OPC_WIDTH-1 -: RUN_WIDTH];

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    kind_d      = kind_q;
    idx_d       = idx_q;
    val_d       = val_q;
    pk_op       = OPC_NOP;
    ins_d       = ins_q;
    ins_valid_d = ins_valid_q && !ins_ready;
    time_d      = time_q;

    if (ins_hs) begin
      if (ins_opc == OPC_RUN)      time_d = time_q + TIME_WIDTH'(ins_cnt);
      else if (ins_opc == OPC_CLR) time_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (evt_acc) begin
          kind_d = evt_kind;
          idx_d  = evt_idx;
          val_d  = evt_val;
          if (evt_dt != '0) begin
            pk_op    = OPC_RUN;
            remain_d = remain_after;
            state_d  = ST_RUN_EMIT;
          end else begin
            remain_d = '0;
            if (evt_kind != EVT_ADV) begin
              pk_op   = kind_to_opc(evt_kind);
              state_d = ST_OP_EMIT;
            end
          end
        end
      end
      ST_RUN_EMIT: begin
        if (slot_free) begin
          if (remain_q != '0) begin
            pk_op    = OPC_RUN;
            remain_d = remain_after;
          end else if (kind_q == EVT_ADV) begin
            state_d = ST_IDLE;
          end else begin
            pk_op   = kind_to_opc(kind_q);
            state_d = ST_OP_EMIT;
          end
        end
      end
      ST_OP_EMIT: begin
        if (ins_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (pk_op != OPC_NOP) begin
      ins_d       = pk_word;
      ins_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= ST_IDLE;
      remain_q    <= '0;
      kind_q      <= EVT_SPK;
      idx_q       <= '0;
      val_q       <= '0;
      ins_q       <= '0;
      ins_valid_q <= 1'b0;
      time_q      <= '0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      kind_q      <= kind_d;
      idx_q       <= idx_d;
      val_q       <= val_d;
      ins_q       <= ins_d;
      ins_valid_q <= ins_valid_d;
      time_q      <= time_d;
    end
  end

  assign ins       = ins_q;
  assign ins_valid = ins_valid_q;
  assign time_now  = time_q;
  assign busy      = (state_q != ST_IDLE) || ins_valid_q;

endmodule

// File: tb/tb_spike_scheduler.sv
// Directed bench for spike_scheduler: a vector table of events with
// hand-computed instruction words, plus backpressure and reset sequences.
module tb_spike_scheduler;
  import spike_scheduler_pkg::*;

  logic                  clk = 1'b0;
  logic                  arstn = 1'b0;
  logic                  evt_valid = 1'b0;
  logic                  evt_ready;
  evt_kind_t             evt_kind = EVT_SPK;
  logic [15:0]           evt_dt = '0;
  logic [IDX_WIDTH-1:0]  evt_idx = '0;
  logic signed [7:0]     evt_val = '0;
  logic                  ins_valid;
  logic                  ins_ready = 1'b1;
  logic [11:0]           ins;
  logic                  busy;
  logic [31:0]           time_now;

  int n_cmp = 0;
  int n_bad = 0;

  spike_scheduler #(
    .RUN_WIDTH (8),
    .DT_WIDTH  (16),
    .TIME_WIDTH(32)
  ) dut (
    .clk      (clk),
    .arstn    (arstn),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_kind (evt_kind),
    .evt_dt   (evt_dt),
    .evt_idx  (evt_idx),
    .evt_val  (evt_val),
    .ins_valid(ins_valid),
    .ins_ready(ins_ready),
    .ins      (ins),
    .busy     (busy),
    .time_now (time_now)
  );

  always #5 clk = ~clk;

  // Expected words, built by hand: {opcode[1:0], payload[9:0]}
  localparam logic [11:0] W_RUN255 = 12'h7FC;  // 01 11111111 00
  localparam logic [11:0] W_RUN90  = 12'h568;  // 01 01011010 00
  localparam logic [11:0] W_RUN3   = 12'h40C;  // 01 00000011 00
  localparam logic [11:0] W_RUN1   = 12'h404;  // 01 00000001 00
  localparam logic [11:0] W_CLR    = 12'hC00;  // 11 0000000000
  localparam logic [11:0] W_SPK_2N3   = 12'hAFD;  // 10 10 11111101
  localparam logic [11:0] W_SPK_1P5   = 12'h905;  // 10 01 00000101
  localparam logic [11:0] W_SPK_3P127 = 12'hB7F;  // 10 11 01111111
  localparam logic [11:0] W_SPK_0N128 = 12'h880;  // 10 00 10000000

  typedef struct packed {
    logic [1:0]       kind;
    logic [15:0]      dt;
    logic [1:0]       idx;
    logic [7:0]       val;
    logic [2:0]       nw;
    logic [3:0][11:0] w;
    logic [31:0]      t;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] kind, input logic [15:0] dt,
                              input logic [1:0] idx, input logic [7:0] val,
                              input logic [2:0] nw, input logic [31:0] t,
                              input logic [11:0] w0, input logic [11:0] w1,
                              input logic [11:0] w2, input logic [11:0] w3);
    vec_t v;
    v.kind = kind; v.dt = dt; v.idx = idx; v.val = val; v.nw = nw; v.t = t;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [1:0] kind, input logic [15:0] dt,
                        input logic [1:0] idx, input logic [7:0] val);
    int guard;
    guard = 0;
    while (!evt_ready && guard < 100) begin
      tick();
      guard++;
    end
    check("evt_ready_wait", {63'd0, evt_ready}, 64'd1);
    evt_kind  = evt_kind_t'(kind);
    evt_dt    = dt;
    evt_idx   = idx;
    evt_val   = val;
    evt_valid = 1'b1;
    tick();
    evt_valid = 1'b0;
  endtask

  task automatic drain(output int nw, output logic [3:0][11:0] got);
    int guard;
    nw = 0;
    got = '0;
    guard = 0;
    while (busy && guard < 2000) begin
      if (ins_valid && ins_ready) begin
        if (nw < 4) got[nw] = ins;
        nw++;
      end
      tick();
      guard++;
    end
    check("drain_bound", {63'd0, busy}, 64'd0);
  endtask

  vec_t             vecs[9];
  int               nw;
  logic [3:0][11:0] got;
  logic             first_vld;

  initial begin
    vecs[0] = mk(EVT_SPK, 16'd0,   2'd2, 8'hFD, 3'd1, 32'd0,   W_SPK_2N3, 0, 0, 0);
    vecs[1] = mk(EVT_SPK, 16'd600, 2'd1, 8'h05, 3'd4, 32'd600, W_RUN255, W_RUN255, W_RUN90, W_SPK_1P5);
    vecs[2] = mk(EVT_ADV, 16'd0,   2'd0, 8'h00, 3'd0, 32'd600, 0, 0, 0, 0);
    vecs[3] = mk(EVT_ADV, 16'd255, 2'd0, 8'h00, 3'd1, 32'd855, W_RUN255, 0, 0, 0);
    vecs[4] = mk(EVT_CLR, 16'd3,   2'd0, 8'h00, 3'd2, 32'd0,   W_RUN3, W_CLR, 0, 0);
    vecs[5] = mk(EVT_ADV, 16'd256, 2'd0, 8'h00, 3'd2, 32'd256, W_RUN255, W_RUN1, 0, 0);
    vecs[6] = mk(EVT_SPK, 16'd1,   2'd3, 8'h7F, 3'd2, 32'd257, W_RUN1, W_SPK_3P127, 0, 0);
    vecs[7] = mk(EVT_SPK, 16'd0,   2'd0, 8'h80, 3'd1, 32'd257, W_SPK_0N128, 0, 0, 0);
    vecs[8] = mk(EVT_CLR, 16'd0,   2'd0, 8'h00, 3'd1, 32'd0,   W_CLR, 0, 0, 0);

    // Reset state
    #2;
    check("rst_ins_valid", {63'd0, ins_valid}, 64'd0);
    check("rst_ins", {52'd0, ins}, 64'd0);
    check("rst_time", {32'd0, time_now}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_evt_ready", {63'd0, evt_ready}, 64'd1);
    tick();
    tick();
    arstn = 1'b1;
    tick();
    check("post_rst_evt_ready", {63'd0, evt_ready}, 64'd1);

    // CLR dt=3 step by step: RUN 3, time 3, then CLR clears time
    accept(EVT_CLR, 16'd3, 2'd0, 8'h00);
    check("clr3_run_word", {52'd0, ins}, {52'd0, W_RUN3});
    check("clr3_time0", {32'd0, time_now}, 64'd0);
    tick();
    check("clr3_clr_word", {52'd0, ins}, {52'd0, W_CLR});
    check("clr3_time3", {32'd0, time_now}, 64'd3);
    tick();
    check("clr3_time_cleared", {32'd0, time_now}, 64'd0);
    check("clr3_idle", {63'd0, busy}, 64'd0);

    // Vector table with ins_ready held high
    for (int i = 0; i < 9; i++) begin
      accept(vecs[i].kind, vecs[i].dt, vecs[i].idx, vecs[i].val);
      first_vld = ins_valid;
      if (vecs[i].nw != 0) begin
        check($sformatf("v%0d_latency", i), {63'd0, first_vld}, 64'd1);
      end else begin
        check($sformatf("v%0d_no_word", i), {63'd0, first_vld}, 64'd0);
        check($sformatf("v%0d_evt_ready", i), {63'd0, evt_ready}, 64'd1);
      end
      drain(nw, got);
      check($sformatf("v%0d_nwords", i), 64'(nw), 64'(vecs[i].nw));
      for (int k = 0; k < 4; k++) begin
        if (k < int'(vecs[i].nw)) begin
          check($sformatf("v%0d_word%0d", i, k), {52'd0, got[k]}, {52'd0, vecs[i].w[k]});
        end
      end
      check($sformatf("v%0d_time", i), {32'd0, time_now}, {32'd0, vecs[i].t});
    end

    // Backpressure mid-RUN: SPK dt=600, stall on the second RUN 255
    accept(EVT_SPK, 16'd600, 2'd1, 8'h05);
    check("bp_first_run", {52'd0, ins}, {52'd0, W_RUN255});
    tick();
    check("bp_time_before", {32'd0, time_now}, 64'd255);
    ins_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("bp_ins_c%0d", c), {52'd0, ins}, {52'd0, W_RUN255});
      check($sformatf("bp_vld_c%0d", c), {63'd0, ins_valid}, 64'd1);
      check($sformatf("bp_evt_ready_c%0d", c), {63'd0, evt_ready}, 64'd0);
      check($sformatf("bp_time_c%0d", c), {32'd0, time_now}, 64'd255);
    end
    ins_ready = 1'b1;
    drain(nw, got);
    check("bp_nwords", 64'(nw), 64'd3);
    check("bp_word0", {52'd0, got[0]}, {52'd0, W_RUN255});
    check("bp_word1", {52'd0, got[1]}, {52'd0, W_RUN90});
    check("bp_word2", {52'd0, got[2]}, {52'd0, W_SPK_1P5});
    check("bp_time_after", {32'd0, time_now}, 64'd600);

    // Asynchronous reset during the second RUN chunk
    accept(EVT_SPK, 16'd600, 2'd2, 8'hFD);
    tick();
    arstn = 1'b0;
    #1;
    check("mid_rst_ins_valid", {63'd0, ins_valid}, 64'd0);
    check("mid_rst_ins", {52'd0, ins}, 64'd0);
    check("mid_rst_time", {32'd0, time_now}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_evt_ready", {63'd0, evt_ready}, 64'd1);
    tick();
    arstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("post_rst_quiet_c%0d", c), {63'd0, ins_valid}, 64'd0);
    end
    accept(EVT_SPK, 16'd0, 2'd2, 8'hFD);
    check("post_rst_latency", {63'd0, ins_valid}, 64'd1);
    drain(nw, got);
    check("post_rst_nwords", 64'(nw), 64'd1);
    check("post_rst_word", {52'd0, got[0]}, {52'd0, W_SPK_2N3});
    check("post_rst_time", {32'd0, time_now}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
